regdst_wb_arbiter: RTL and testbench

//  Write-back arbiter/sequencer for the register-file write port. Up to NREQ

---
 rtl/regdst_wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regdst_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regdst_wb_arbiter.sv
// regdst_wb_arbiter: round-robin write-back arbiter feeding the RegDst mux and
// the register-file write port. One grant per cycle; a busy regfile (wb_hold)
// freezes the pending write until it is accepted.
// Optional feature macro: WB_ZERO_GUARD_EN (drop writes resolving to $zero and
// count them on zero_drop_cnt).
module regdst_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_sel,
  input  logic [5*NREQ-1:0]      req_rt,
  input  logic [16*NREQ-1:0]     req_rd16,
  input  logic [5*NREQ-1:0]      req_rs,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic                   wb_hold,
  output logic [2:0]             wb_sel,
  output logic [4:0]             wb_rt,
  output logic [15:0]            wb_rd16,
  output logic [4:0]             wb_rs,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   reg_write,
  output logic [IDX_W-1:0]       wb_grant_id,
  output logic                   err_bad_sel
`ifdef WB_ZERO_GUARD_EN
  ,
  output logic [7:0]             zero_drop_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               grant;
  logic               stall;
  logic [2:0]         sel_w;
  logic [4:0]         rt_w;
  logic [15:0]        rd16_w;
  logic [4:0]         rs_w;
  logic [DATA_W-1:0]  data_w;
  logic               bad_sel;
  logic               write_ok;
`ifdef WB_ZERO_GUARD_EN
  logic [4:0]         dest_w;
  logic               dest_zero;
`endif

  // A presented write that the regfile cannot take yet blocks new grants
  assign stall = reg_write & wb_hold;

  // First valid requester at or after the rr pointer, wrapping
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_q) + k) % NREQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  // Winner's fields, muxed by constant slice to keep indexing simple
  always_comb begin
    sel_w  = '0;
    rt_w   = '0;
    rd16_w = '0;
    rs_w   = '0;
    data_w = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_w  = req_sel[3*i +: 3];
        rt_w   = req_rt[5*i +: 5];
        rd16_w = req_rd16[16*i +: 16];
        rs_w   = req_rs[5*i +: 5];
        data_w = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign bad_sel = sel_w[2] & (sel_w[1] | sel_w[0]);

`ifdef WB_ZERO_GUARD_EN
  // Resolved destination register per RegDst code
  always_comb begin
    dest_w = 5'd0;
    unique case (sel_w)
      3'b000:  dest_w = rt_w;
      3'b001:  dest_w = 5'd29;
      3'b010:  dest_w = 5'd31;
      3'b011:  dest_w = rd16_w[15:11];
      3'b100:  dest_w = rs_w;
      default: dest_w = 5'd0;
    endcase
  end
  assign dest_zero = (dest_w == 5'd0);
  assign write_ok  = !bad_sel && !dest_zero;
`else
  assign write_ok  = !bad_sel;
`endif

  // FSM next state and grant; req_ready forced low during reset
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (stall) state_d = HOLD;
        else       grant   = pick_found;
      end
      HOLD: begin
        if (!wb_hold) begin
          state_d = IDLE;
          grant   = pick_found;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant && !reset) req_ready = NREQ'(1) << pick_idx;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Write-back register stage and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= '0;
      wb_sel      <= '0;
      wb_rt       <= '0;
      wb_rd16     <= '0;
      wb_rs       <= '0;
      wb_data     <= '0;
      reg_write   <= 1'b0;
      wb_grant_id <= '0;
      err_bad_sel <= 1'b0;
    end else if (grant) begin
      wb_sel      <= sel_w;
      wb_rt       <= rt_w;
      wb_rd16     <= rd16_w;
      wb_rs       <= rs_w;
      wb_data     <= data_w;
      reg_write   <= write_ok;
      wb_grant_id <= pick_idx;
      rr_q        <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      if (bad_sel) err_bad_sel <= 1'b1;
    end else if (!stall) begin
      reg_write   <= 1'b0;
    end
  end

`ifdef WB_ZERO_GUARD_EN
  // Saturating count of writes dropped for targeting $zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_drop_cnt <= 8'd0;
    else if (grant && !bad_sel && dest_zero && zero_drop_cnt != 8'hFF)
      zero_drop_cnt <= zero_drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_regdst_wb_arbiter.sv
// Bench for regdst_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural reference model.
module tb_regdst_wb_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [3*NREQ-1:0]      req_sel;
  logic [5*NREQ-1:0]      req_rt;
  logic [16*NREQ-1:0]     req_rd16;
  logic [5*NREQ-1:0]      req_rs;
  logic [DATA_W*NREQ-1:0] req_data;
  logic                   wb_hold;
  logic [2:0]             wb_sel;
  logic [4:0]             wb_rt;
  logic [15:0]            wb_rd16;
  logic [4:0]             wb_rs;
  logic [DATA_W-1:0]      wb_data;
  logic                   reg_write;
  logic [IDX_W-1:0]       wb_grant_id;
  logic                   err_bad_sel;
`ifdef WB_ZERO_GUARD_EN
  logic [7:0]             zero_drop_cnt;
`endif

  regdst_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_rt(req_rt), .req_rd16(req_rd16),
    .req_rs(req_rs), .req_data(req_data), .wb_hold(wb_hold),
    .wb_sel(wb_sel), .wb_rt(wb_rt), .wb_rd16(wb_rd16), .wb_rs(wb_rs),
    .wb_data(wb_data), .reg_write(reg_write), .wb_grant_id(wb_grant_id),
    .err_bad_sel(err_bad_sel)
`ifdef WB_ZERO_GUARD_EN
    , .zero_drop_cnt(zero_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Per-requester stimulus, packed onto the DUT buses
  logic [2:0]        t_sel  [NREQ];
  logic [4:0]        t_rt   [NREQ];
  logic [15:0]       t_rd16 [NREQ];
  logic [4:0]        t_rs   [NREQ];
  logic [DATA_W-1:0] t_data [NREQ];

  always_comb begin
    req_sel = '0; req_rt = '0; req_rd16 = '0; req_rs = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_sel[3*i +: 3]            = t_sel[i];
      req_rt[5*i +: 5]             = t_rt[i];
      req_rd16[16*i +: 16]         = t_rd16[i];
      req_rs[5*i +: 5]             = t_rs[i];
      req_data[DATA_W*i +: DATA_W] = t_data[i];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state
  int          m_rr, m_win, m_cnt, m_id;
  bit          m_rw, m_err, m_stall;
  logic [2:0]  m_sel;
  logic [4:0]  m_rt, m_rs;
  logic [15:0] m_rd16;
  logic [31:0] m_data;
  logic [NREQ-1:0] m_ready;

  function automatic int dest_of(input int i);
    case (t_sel[i])
      3'd0:    return int'(t_rt[i]);
      3'd1:    return 29;
      3'd2:    return 31;
      3'd3:    return int'(t_rd16[i] >> 11);
      3'd4:    return int'(t_rs[i]);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_rr = 0; m_rw = 0; m_err = 0; m_cnt = 0; m_id = 0;
    m_sel = 0; m_rt = 0; m_rs = 0; m_rd16 = 0; m_data = 0;
  endtask

  // Decide this cycle's grant from the current inputs
  task automatic model_comb();
    m_stall = m_rw && wb_hold;
    m_win = -1;
    if (!m_stall)
      for (int k = 0; k < NREQ; k++)
        if (m_win < 0 && req_valid[(m_rr + k) % NREQ]) m_win = (m_rr + k) % NREQ;
    m_ready = (m_win < 0) ? '0 : NREQ'(1 << m_win);
  endtask

  // Apply the decided grant at the clock edge
  task automatic model_edge();
    bit bad, zero;
    if (m_win >= 0) begin
      bad  = t_sel[m_win] > 3'd4;
      zero = !bad && dest_of(m_win) == 0;
      m_sel = t_sel[m_win]; m_rt = t_rt[m_win]; m_rd16 = t_rd16[m_win];
      m_rs = t_rs[m_win]; m_data = t_data[m_win]; m_id = m_win;
`ifdef WB_ZERO_GUARD_EN
      m_rw = !bad && !zero;
      if (zero && m_cnt < 255) m_cnt++;
`else
      m_rw = !bad;
`endif
      if (bad) m_err = 1;
      m_rr = (m_win + 1) % NREQ;
    end else if (!m_stall) begin
      m_rw = 0;
    end
  endtask

  task automatic check_outputs();
    check("reg_write", 64'(reg_write), 64'(m_rw));
    check("wb_sel", 64'(wb_sel), 64'(m_sel));
    check("wb_rt", 64'(wb_rt), 64'(m_rt));
    check("wb_rd16", 64'(wb_rd16), 64'(m_rd16));
    check("wb_rs", 64'(wb_rs), 64'(m_rs));
    check("wb_data", 64'(wb_data), 64'(m_data));
    check("wb_grant_id", 64'(wb_grant_id), 64'(m_id));
    check("err_bad_sel", 64'(err_bad_sel), 64'(m_err));
`ifdef WB_ZERO_GUARD_EN
    check("zero_drop_cnt", 64'(zero_drop_cnt), 64'(m_cnt));
`endif
  endtask

  // One clock: check grant before the edge, registered outputs after it
  task automatic step();
    #1;
    model_comb();
    check("req_ready", 64'(req_ready), 64'(m_ready));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic [2:0] s, input logic [4:0] rt,
                         input logic [15:0] rd, input logic [4:0] rs, input logic [31:0] d);
    t_sel[i] = s; t_rt[i] = rt; t_rd16[i] = rd; t_rs[i] = rs; t_data[i] = d;
  endtask

  initial begin
    reset = 1'b1; wb_hold = 1'b0; req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 5'd5, 16'h0, 5'd0, 32'(i + 1));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_err", 64'(err_bad_sel), 64'd0);

    // Round-robin with everyone requesting
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_grant_id", 64'(wb_grant_id), 64'(i % 3));
    end

    // Hold freezes the write and blocks grants; release grants in same cycle
    req_valid = 3'b010;
    set_req(1, 3'b010, 5'd1, 16'h0, 5'd2, 32'hDEAD_BEEF);
    step();
    check("hold_data", 64'(wb_data), 64'hDEAD_BEEF);
    req_valid = 3'b100; wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_frozen", 64'(wb_data), 64'hDEAD_BEEF);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    wb_hold = 1'b0;
    #1 check("release_ready", 64'(req_ready), 64'b100);
    step();
    check("release_id", 64'(wb_grant_id), 64'd2);

    // Bad select is consumed without a write and latches the error flag
    req_valid = 3'b001;
    set_req(0, 3'b110, 5'd3, 16'h0, 5'd4, 32'h55);
    #1 check("bad_ready", 64'(req_ready), 64'b001);
    step();
    check("bad_reg_write", 64'(reg_write), 64'd0);
    check("bad_err", 64'(err_bad_sel), 64'd1);

    // Field routing through the rd16 input
    req_valid = 3'b100;
    set_req(2, 3'b011, 5'd9, 16'h5800, 5'd10, 32'd7);
    step();
    check("route_sel", 64'(wb_sel), 64'b011);
    check("route_rd16", 64'(wb_rd16), 64'h5800);
    check("route_write", 64'(reg_write), 64'd1);
    check("err_sticky", 64'(err_bad_sel), 64'd1);

    // Write targeting $zero
    req_valid = 3'b001;
    set_req(0, 3'b000, 5'd0, 16'h0, 5'd6, 32'h99);
    step();
`ifdef WB_ZERO_GUARD_EN
    check("zero_write", 64'(reg_write), 64'd0);
    check("zero_cnt", 64'(zero_drop_cnt), 64'd1);
`else
    check("zero_write", 64'(reg_write), 64'd1);
`endif

    // Randomized traffic with random regfile back-pressure
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      wb_hold   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++)
        set_req(i, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                16'($urandom), 5'($urandom_range(0, 3)), $urandom);
      step();
    end

    // Asynchronous reset mid-stream clears everything at once
    req_valid = 3'b111; wb_hold = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 5'd5, 16'h0, 5'd0, 32'(i + 1));
    step();
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_ready", 64'(req_ready), 64'd0);
    check_outputs();
    @(negedge clk) reset = 1'b0;
    step();
    check("post_rst_id", 64'(wb_grant_id), 64'd0);
    check("post_rst_write", 64'(reg_write), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
